operand_bypass_net: RTL and testbench

//  Parametrised EX-stage operand network: tracks the last DEPTH in-flight producers (rd, value, value-valid)
//  in an internal shift pipeline and forwards the youngest matching value to rs1/rs2.

---
 rtl/operand_bypass_net.sv | 199 +++++++++++++++++++
 tb/tb_operand_bypass_net.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/operand_bypass_net.sv
// operand_bypass_net: EX-stage operand network.
// Tracks the last DEPTH register-writing producers in a shift pipeline
// (stage 0 = MEM, 1 = WB, 2.. = post-WB). Each source operand takes the value
// from the youngest matching producer, or from the register file if none matches.
// A match on a load whose data has not returned yet raises a load-use stall.
// Also selects ALU operands A/B (PC for AUIPC, I/S/U immediates) and counts
// stall cycles.
// Ports:
//   clock, reset_n            rising-edge clock, async active-low reset
//   ex_valid/ex_ir/ex_pc      EX instruction (valid, word, PC)
//   ex_rs1_val/ex_rs2_val     register-file source values
//   ex_result                 ALU result of the EX instruction, captured when it fires
//   mem_hold                  freezes the tracker (external memory stall)
//   ld_data_valid/ld_data     load data for the stage-0 record
//   ain/bin                   ALU operands A/B (combinational)
//   store_data                forwarded rs2 (combinational)
//   stall                     hold EX/IF/ID and inject a bubble (combinational)
//   fwd_hit                   [0]=rs1, [1]=rs2 taken from the tracker (combinational)
//   stall_cnt                 saturating count of stall cycles (registered)
module operand_bypass_net #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned DEPTH = 3,
    parameter int unsigned RAW   = 5,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             ex_valid,
    input  logic [31:0]      ex_ir,
    input  logic [XLEN-1:0]  ex_pc,
    input  logic [XLEN-1:0]  ex_rs1_val,
    input  logic [XLEN-1:0]  ex_rs2_val,
    input  logic [XLEN-1:0]  ex_result,
    input  logic             mem_hold,
    input  logic             ld_data_valid,
    input  logic [XLEN-1:0]  ld_data,
    output logic [XLEN-1:0]  ain,
    output logic [XLEN-1:0]  bin,
    output logic [XLEN-1:0]  store_data,
    output logic             stall,
    output logic [1:0]       fwd_hit,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    typedef struct packed {
        logic            vld;
        logic [RAW-1:0]  rd;
        logic            is_ld;
        logic [XLEN-1:0] val;
        logic            val_ok;
    } rec_t;

    rec_t stage_q [DEPTH];

    logic [6:0]      opcode;
    logic [RAW-1:0]  rd, rs1, rs2;
    logic            use_rs1, use_rs2, writes_rd, is_load;
    logic [XLEN-1:0] imm_i, imm_s, imm_u;
    logic            hit1, ok1, hit2, ok2;
    logic [XLEN-1:0] val1, val2;
    logic [XLEN-1:0] rs1_fwd, rs2_fwd;
    logic            fire, fill;
    rec_t            push_rec, fill_rec;

    // Instruction field decode
    assign opcode  = ex_ir[6:0];
    assign rd      = RAW'(ex_ir[11:7]);
    assign rs1     = RAW'(ex_ir[19:15]);
    assign rs2     = RAW'(ex_ir[24:20]);
    assign is_load = (opcode == OPC_LOAD);

    assign imm_i = XLEN'($signed(ex_ir[31:20]));
    assign imm_s = XLEN'($signed({ex_ir[31:25], ex_ir[11:7]}));
    assign imm_u = XLEN'($signed({ex_ir[31:12], 12'b0}));

    // Which sources the opcode reads and whether it writes rd
    always_comb begin
        use_rs1   = 1'b0;
        use_rs2   = 1'b0;
        writes_rd = 1'b0;
        case (opcode)
            OPC_OP: begin
                use_rs1   = 1'b1;
                use_rs2   = 1'b1;
                writes_rd = 1'b1;
            end
            OPC_OPIMM, OPC_LOAD, OPC_JALR: begin
                use_rs1   = 1'b1;
                writes_rd = 1'b1;
            end
            OPC_STORE, OPC_BRANCH: begin
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
            end
            OPC_LUI, OPC_AUIPC, OPC_JAL: begin
                writes_rd = 1'b1;
            end
            default: ;
        endcase
    end

    // Youngest-match search: scan oldest to youngest so the lowest index wins
    always_comb begin
        hit1 = 1'b0;
        ok1  = 1'b0;
        val1 = '0;
        hit2 = 1'b0;
        ok2  = 1'b0;
        val2 = '0;
        for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
            if (stage_q[i].vld && (rs1 != '0) && (stage_q[i].rd == rs1)) begin
                hit1 = 1'b1;
                ok1  = stage_q[i].val_ok;
                val1 = stage_q[i].val;
            end
            if (stage_q[i].vld && (rs2 != '0) && (stage_q[i].rd == rs2)) begin
                hit2 = 1'b1;
                ok2  = stage_q[i].val_ok;
                val2 = stage_q[i].val;
            end
        end
    end

    assign rs1_fwd    = (hit1 && ok1) ? val1 : ex_rs1_val;
    assign rs2_fwd    = (hit2 && ok2) ? val2 : ex_rs2_val;
    assign fwd_hit    = {use_rs2 & hit2 & ok2, use_rs1 & hit1 & ok1};
    assign stall      = ex_valid & ((use_rs1 & hit1 & ~ok1) | (use_rs2 & hit2 & ~ok2));
    assign fire       = ex_valid & ~stall & ~mem_hold;
    assign store_data = rs2_fwd;

    // ALU operand select
    always_comb begin
        ain = rs1_fwd;
        bin = rs2_fwd;
        case (opcode)
            OPC_AUIPC: ain = ex_pc;
            OPC_LUI:   ain = '0;
            default: ;
        endcase
        case (opcode)
            OPC_OPIMM, OPC_LOAD, OPC_JALR: bin = imm_i;
            OPC_STORE:                     bin = imm_s;
            OPC_LUI, OPC_AUIPC:            bin = imm_u;
            default: ;
        endcase
    end

    // New stage-0 record and load-data fill of the current stage-0 record
    always_comb begin
        push_rec = '0;
        if (fire && writes_rd && (rd != '0)) begin
            push_rec.vld    = 1'b1;
            push_rec.rd     = rd;
            push_rec.is_ld  = is_load;
            push_rec.val    = ex_result;
            push_rec.val_ok = ~is_load;
        end
        fill            = ld_data_valid & stage_q[0].vld & stage_q[0].is_ld & ~stage_q[0].val_ok;
        fill_rec        = stage_q[0];
        fill_rec.val    = ld_data;
        fill_rec.val_ok = 1'b1;
    end

    // Producer tracker: shift when not held; a fill lands on wherever the stage-0 record ends up
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                stage_q[i] <= '0;
            end
        end else if (!mem_hold) begin
            stage_q[0] <= push_rec;
            for (int i = 1; i < int'(DEPTH); i++) begin
                stage_q[i] <= ((i == 1) && fill) ? fill_rec : stage_q[i-1];
            end
        end else if (fill) begin
            stage_q[0] <= fill_rec;
        end
    end

    // Saturating stall-cycle counter
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            stall_cnt <= '0;
        end else if (stall && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_operand_bypass_net.sv
module tb_operand_bypass_net;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned DEPTH = 3;

    localparam logic [6:0] OP     = 7'b0110011;
    localparam logic [6:0] OPIMM  = 7'b0010011;
    localparam logic [6:0] LOAD   = 7'b0000011;
    localparam logic [6:0] STORE  = 7'b0100011;
    localparam logic [6:0] BRANCH = 7'b1100011;
    localparam logic [6:0] LUI    = 7'b0110111;
    localparam logic [6:0] AUIPC  = 7'b0010111;
    localparam logic [6:0] JAL    = 7'b1101111;
    localparam logic [6:0] JALR   = 7'b1100111;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        ex_valid, mem_hold, ld_data_valid;
    logic [31:0] ex_ir, ex_pc, ex_rs1_val, ex_rs2_val, ex_result, ld_data;
    logic [31:0] ain, bin, store_data;
    logic        stall;
    logic [1:0]  fwd_hit;
    logic [15:0] stall_cnt;
    logic [31:0] ain_s, bin_s, store_data_s;
    logic        stall_s;
    logic [1:0]  fwd_hit_s;
    logic [2:0]  stall_cnt_s;

    int total = 0;
    int bad   = 0;

    always #5 clock = ~clock;

    operand_bypass_net dut (
        .clock(clock), .reset_n(reset_n), .ex_valid(ex_valid), .ex_ir(ex_ir), .ex_pc(ex_pc),
        .ex_rs1_val(ex_rs1_val), .ex_rs2_val(ex_rs2_val), .ex_result(ex_result),
        .mem_hold(mem_hold), .ld_data_valid(ld_data_valid), .ld_data(ld_data),
        .ain(ain), .bin(bin), .store_data(store_data), .stall(stall),
        .fwd_hit(fwd_hit), .stall_cnt(stall_cnt)
    );

    // Narrow counter instance to reach saturation quickly
    operand_bypass_net #(.CNT_W(3)) dut_s (
        .clock(clock), .reset_n(reset_n), .ex_valid(ex_valid), .ex_ir(ex_ir), .ex_pc(ex_pc),
        .ex_rs1_val(ex_rs1_val), .ex_rs2_val(ex_rs2_val), .ex_result(ex_result),
        .mem_hold(mem_hold), .ld_data_valid(ld_data_valid), .ld_data(ld_data),
        .ain(ain_s), .bin(bin_s), .store_data(store_data_s), .stall(stall_s),
        .fwd_hit(fwd_hit_s), .stall_cnt(stall_cnt_s)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Instruction encoders
    function automatic logic [31:0] e_addi(input int rd, input int rs1, input int imm);
        return {12'(imm), 5'(rs1), 3'b000, 5'(rd), OPIMM};
    endfunction
    function automatic logic [31:0] e_add(input int rd, input int rs1, input int rs2);
        return {7'b0, 5'(rs2), 5'(rs1), 3'b000, 5'(rd), OP};
    endfunction
    function automatic logic [31:0] e_lw(input int rd, input int rs1, input int imm);
        return {12'(imm), 5'(rs1), 3'b010, 5'(rd), LOAD};
    endfunction
    function automatic logic [31:0] e_sw(input int rs2, input int rs1, input int imm);
        logic [11:0] im;
        im = 12'(imm);
        return {im[11:5], 5'(rs2), 5'(rs1), 3'b010, im[4:0], STORE};
    endfunction
    function automatic logic [31:0] e_u(input logic [6:0] opc, input int rd, input int imm20);
        return {20'(imm20), 5'(rd), opc};
    endfunction

    task automatic set_in(input logic v, input logic [31:0] ir, input logic [31:0] pc,
                          input logic [31:0] r1, input logic [31:0] r2, input logic [31:0] res,
                          input logic hold, input logic ldv, input logic [31:0] ldd);
        ex_valid = v; ex_ir = ir; ex_pc = pc; ex_rs1_val = r1; ex_rs2_val = r2;
        ex_result = res; mem_hold = hold; ld_data_valid = ldv; ld_data = ldd;
    endtask

    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    // Reference model: list of producers, youngest first
    typedef struct {
        bit          vld;
        int unsigned rd;
        bit          ld;
        logic [31:0] val;
        bit          ok;
    } mrec_t;

    mrec_t       hist[$];
    int unsigned mcnt, mcnt_s;

    function automatic void model_clear();
        mrec_t z;
        z = '{0, 0, 0, 32'h0, 0};
        hist.delete();
        for (int i = 0; i < int'(DEPTH); i++) hist.push_back(z);
        mcnt   = 0;
        mcnt_s = 0;
    endfunction

    function automatic void look(input int unsigned rs, output bit hit, output bit ok,
                                 output logic [31:0] val);
        hit = 0; ok = 0; val = '0;
        if (rs == 0) return;
        foreach (hist[i]) begin
            if (hist[i].vld && hist[i].rd == rs) begin
                hit = 1; ok = hist[i].ok; val = hist[i].val;
                return;
            end
        end
    endfunction

    task automatic do_reset();
        reset_n = 1'b0;
        set_in(1'b1, e_add(1, 2, 3), 32'h0, 32'h11, 32'h22, 32'h0, 1'b0, 1'b0, 32'h0);
        @(negedge clock);
        chk("rst_stall", 32'(stall), 32'h0);
        chk("rst_hit", 32'(fwd_hit), 32'h0);
        chk("rst_cnt", 32'(stall_cnt), 32'h0);
        chk("rst_ain", ain, 32'h11);
        chk("rst_bin", bin, 32'h22);
        next_cycle();
        reset_n = 1'b1;
        model_clear();
    endtask

    typedef struct {
        logic        v;
        logic [31:0] ir, pc, r1, r2, res;
        logic        hold, ldv;
        logic [31:0] ldd;
        logic        chk_ops;
        logic [31:0] e_ain, e_bin, e_sd;
        logic        e_stall;
        logic [1:0]  e_hit;
        logic [15:0] e_cnt;
    } vec_t;

    function automatic vec_t mk(input logic v, input logic [31:0] ir, input logic [31:0] pc,
                                input logic [31:0] r1, input logic [31:0] r2, input logic [31:0] res,
                                input logic hold, input logic ldv, input logic [31:0] ldd,
                                input logic chk_ops, input logic [31:0] e_ain, input logic [31:0] e_bin,
                                input logic [31:0] e_sd, input logic e_stall, input logic [1:0] e_hit,
                                input logic [15:0] e_cnt);
        vec_t t;
        t = '{v, ir, pc, r1, r2, res, hold, ldv, ldd, chk_ops, e_ain, e_bin, e_sd, e_stall, e_hit, e_cnt};
        return t;
    endfunction

    vec_t vt[$];

    initial begin
        logic [6:0] opcs [9];
        opcs = '{OP, OPIMM, LOAD, STORE, BRANCH, LUI, AUIPC, JAL, JALR};

        reset_n = 1'b0;
        set_in(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
        #2;
        next_cycle();
        do_reset();

        // Directed vectors: forwarding, load-use, youngest-wins, x0, store, LUI/AUIPC
        vt.push_back(mk(1, e_addi(1, 0, 5),      32'h100, 0, 0, 5,            0, 0, 0,            1, 0, 5, 0, 0, 2'b00, 0));
        vt.push_back(mk(1, e_add(2, 1, 1),       32'h104, 0, 0, 10,           0, 0, 0,            1, 5, 5, 5, 0, 2'b11, 0));
        vt.push_back(mk(1, e_lw(3, 0, 0),        32'h108, 0, 0, 32'h1234,     0, 0, 0,            1, 0, 0, 0, 0, 2'b00, 0));
        vt.push_back(mk(1, e_add(4, 3, 0),       32'h10c, 0, 0, 0,            0, 1, 32'hDEADBEEF, 0, 0, 0, 0, 1, 2'b00, 0));
        vt.push_back(mk(1, e_add(4, 3, 0),       32'h10c, 0, 0, 32'hDEADBEEF, 0, 0, 0,            1, 32'hDEADBEEF, 0, 0, 0, 2'b01, 1));
        vt.push_back(mk(1, e_addi(5, 0, 1),      32'h110, 0, 0, 1,            0, 0, 0,            1, 0, 1, 0, 0, 2'b00, 1));
        vt.push_back(mk(1, e_addi(5, 0, 2),      32'h114, 0, 0, 2,            0, 0, 0,            1, 0, 2, 0, 0, 2'b00, 1));
        vt.push_back(mk(1, e_add(6, 5, 0),       32'h118, 0, 0, 2,            0, 0, 0,            1, 2, 0, 0, 0, 2'b01, 1));
        vt.push_back(mk(1, e_addi(0, 0, 7),      32'h11c, 0, 0, 7,            0, 0, 0,            1, 0, 7, 0, 0, 2'b00, 1));
        vt.push_back(mk(1, e_add(1, 0, 0),       32'h120, 0, 0, 0,            0, 0, 0,            1, 0, 0, 0, 0, 2'b00, 1));
        vt.push_back(mk(1, e_addi(8, 0, 'h55),   32'h124, 0, 0, 32'h55,       0, 0, 0,            1, 0, 32'h55, 0, 0, 2'b00, 1));
        vt.push_back(mk(1, e_sw(8, 9, -4),       32'h128, 32'h100, 0, 32'hFC, 0, 0, 0,            1, 32'h100, 32'hFFFFFFFC, 32'h55, 0, 2'b10, 1));
        vt.push_back(mk(1, e_u(LUI, 10, 'h12345), 32'h12c, 0, 32'h777, 32'h12345000, 0, 0, 0,    1, 0, 32'h12345000, 32'h777, 0, 2'b00, 1));
        vt.push_back(mk(1, e_u(AUIPC, 11, 1),    32'h400, 0, 0, 32'h1400,     0, 0, 0,            1, 32'h400, 32'h1000, 0, 0, 2'b00, 1));
        vt.push_back(mk(1, e_add(12, 10, 11),    32'h404, 0, 0, 32'h0,        0, 0, 0,            1, 32'h12345000, 32'h1400, 32'h1400, 0, 2'b11, 1));

        for (int k = 0; k < vt.size(); k++) begin
            set_in(vt[k].v, vt[k].ir, vt[k].pc, vt[k].r1, vt[k].r2, vt[k].res,
                   vt[k].hold, vt[k].ldv, vt[k].ldd);
            @(negedge clock);
            chk($sformatf("v%0d_stall", k), 32'(stall), 32'(vt[k].e_stall));
            chk($sformatf("v%0d_hit", k), 32'(fwd_hit), 32'(vt[k].e_hit));
            chk($sformatf("v%0d_cnt", k), 32'(stall_cnt), 32'(vt[k].e_cnt));
            if (vt[k].chk_ops) begin
                chk($sformatf("v%0d_ain", k), ain, vt[k].e_ain);
                chk($sformatf("v%0d_bin", k), bin, vt[k].e_bin);
                chk($sformatf("v%0d_sd", k), store_data, vt[k].e_sd);
            end
            next_cycle();
        end

        // Load held by mem_hold for three cycles, then data returns
        do_reset();
        set_in(1, e_lw(7, 0, 0), 32'h200, 0, 0, 32'h0, 0, 0, 0);
        @(negedge clock);
        chk("mh_lw_stall", 32'(stall), 32'h0);
        next_cycle();
        for (int k = 0; k < 3; k++) begin
            set_in(1, e_add(12, 7, 0), 32'h204, 32'h99, 0, 32'h5, 1, 0, 0);
            @(negedge clock);
            chk($sformatf("mh_hold%0d_stall", k), 32'(stall), 32'h1);
            chk($sformatf("mh_hold%0d_cnt", k), 32'(stall_cnt), 32'(k));
            next_cycle();
        end
        set_in(1, e_add(12, 7, 0), 32'h204, 32'h99, 0, 32'h5, 0, 1, 32'hCAFE);
        @(negedge clock);
        chk("mh_fill_stall", 32'(stall), 32'h1);
        chk("mh_fill_cnt", 32'(stall_cnt), 32'h3);
        next_cycle();
        set_in(1, e_add(12, 7, 0), 32'h204, 32'h99, 0, 32'h5, 0, 0, 0);
        @(negedge clock);
        chk("mh_use_stall", 32'(stall), 32'h0);
        chk("mh_use_ain", ain, 32'hCAFE);
        chk("mh_use_hit", 32'(fwd_hit), 32'h1);
        chk("mh_use_cnt", 32'(stall_cnt), 32'h4);
        next_cycle();
        set_in(1, e_add(14, 7, 0), 32'h208, 32'h99, 0, 32'h6, 0, 0, 0);
        @(negedge clock);
        chk("mh_oldest_ain", ain, 32'hCAFE);
        next_cycle();
        set_in(1, e_add(15, 7, 0), 32'h20c, 32'h99, 0, 32'h7, 0, 0, 0);
        @(negedge clock);
        chk("mh_dropped_ain", ain, 32'h99);
        chk("mh_dropped_hit", 32'(fwd_hit), 32'h0);
        next_cycle();

        // Reset asserted in the middle of a load-use stall
        do_reset();
        set_in(1, e_lw(3, 0, 0), 32'h300, 0, 0, 32'h0, 0, 0, 0);
        next_cycle();
        set_in(1, e_add(4, 3, 0), 32'h304, 32'h44, 0, 32'h0, 0, 0, 0);
        next_cycle();
        @(negedge clock);
        chk("rm_pre_stall", 32'(stall), 32'h1);
        chk("rm_pre_cnt", 32'(stall_cnt), 32'h1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("rm_stall", 32'(stall), 32'h0);
        chk("rm_cnt", 32'(stall_cnt), 32'h0);
        chk("rm_ain", ain, 32'h44);
        next_cycle();
        reset_n = 1'b1;
        model_clear();

        // Randomised traffic against the reference model
        for (int n = 0; n < 3000; n++) begin
            logic [31:0] ir, pc, r1, r2, res, ldd, v1, v2, f1, f2, ea, eb;
            logic [6:0]  opc;
            logic        v, hold, ldv;
            bit          u1, u2, wr, h1, k1, h2, k2, p1, p2, e_stall, da, db, fire, fillc;
            logic [1:0]  e_hit;
            mrec_t       nr;

            opc = opcs[$urandom_range(0, 8)];
            ir  = $urandom;
            ir[6:0]   = opc;
            ir[11:7]  = 5'($urandom_range(0, 3));
            ir[19:15] = 5'($urandom_range(0, 3));
            ir[24:20] = 5'($urandom_range(0, 3));
            pc = $urandom; r1 = $urandom; r2 = $urandom; res = $urandom; ldd = $urandom;
            v    = ($urandom_range(0, 9) < 9);
            hold = ($urandom_range(0, 4) == 0);
            ldv  = ($urandom_range(0, 2) == 0);

            u1 = (opc == OP) || (opc == OPIMM) || (opc == LOAD) || (opc == JALR) ||
                 (opc == STORE) || (opc == BRANCH);
            u2 = (opc == OP) || (opc == STORE) || (opc == BRANCH);
            wr = !((opc == STORE) || (opc == BRANCH));

            look(int'(ir[19:15]), h1, k1, v1);
            look(int'(ir[24:20]), h2, k2, v2);
            p1 = h1 && !k1;
            p2 = h2 && !k2;
            f1 = (h1 && k1) ? v1 : r1;
            f2 = (h2 && k2) ? v2 : r2;
            e_stall = v && ((u1 && p1) || (u2 && p2));
            e_hit   = {u2 && h2 && k2, u1 && h1 && k1};

            da = 1; db = 1;
            if (opc == AUIPC)    ea = pc;
            else if (opc == LUI) ea = 0;
            else begin ea = f1; da = u1 && !p1; end
            if (opc == OPIMM || opc == LOAD || opc == JALR) eb = 32'($signed(ir[31:20]));
            else if (opc == STORE)                          eb = 32'($signed({ir[31:25], ir[11:7]}));
            else if (opc == LUI || opc == AUIPC)            eb = {ir[31:12], 12'h0};
            else begin eb = f2; db = u2 && !p2; end

            set_in(v, ir, pc, r1, r2, res, hold, ldv, ldd);
            @(negedge clock);
            chk("rnd_stall", 32'(stall), 32'(e_stall));
            chk("rnd_hit", 32'(fwd_hit), 32'(e_hit));
            chk("rnd_cnt", 32'(stall_cnt), mcnt);
            chk("rnd_cnt3", 32'(stall_cnt_s), mcnt_s);
            chk("rnd_stall3", 32'(stall_s), 32'(e_stall));
            if (da) chk("rnd_ain", ain, ea);
            if (db) chk("rnd_bin", bin, eb);
            if (!p2) chk("rnd_sd", store_data, f2);
            next_cycle();

            if (e_stall) begin
                if (mcnt < 65535) mcnt++;
                if (mcnt_s < 7) mcnt_s++;
            end
            fire  = v && !e_stall && !hold;
            fillc = ldv && hist[0].vld && hist[0].ld && !hist[0].ok;
            if (!hold) begin
                nr = '{0, 0, 0, 32'h0, 0};
                if (fire && wr && ir[11:7] != 0)
                    nr = '{1, int'(ir[11:7]), opc == LOAD, res, opc != LOAD};
                hist.push_front(nr);
                void'(hist.pop_back());
                if (fillc) begin
                    hist[1].val = ldd;
                    hist[1].ok  = 1;
                end
            end else if (fillc) begin
                hist[0].val = ldd;
                hist[0].ok  = 1;
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
